udp_40g_traffic_gen: RTL and testbench



---
 rtl/udp_40g_traffic_gen.sv | 262 ++++++++++++++++++++++++++
 tb/tb_udp_40g_traffic_gen.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_40g_traffic_gen.sv
// Synthetic UDP payload generator: numbered, self-describing frames on a 128-bit
// AXI4-Stream master with runtime length, count and inter-packet gap.
module udp_40g_traffic_gen #(
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned MAX_LEN = 8192,
  parameter int unsigned MIN_LEN = 16
) (
  input  logic                  sys_clk,
  input  logic                  sys_reset_n,
  input  logic                  cfg_start,
  input  logic                  cfg_stop,
  input  logic [15:0]           cfg_pkt_len,
  input  logic [31:0]           cfg_pkt_count,
  input  logic [7:0]            cfg_gap,
  output logic [DATA_W-1:0]     m_axis_tdata,
  output logic [DATA_W/8-1:0]   m_axis_tkeep,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           tx_pkt_cnt,
  output logic [47:0]           tx_byte_cnt
);

  localparam int unsigned KEEP_W = DATA_W / 8;
  localparam int unsigned OFF_W  = $clog2(KEEP_W);
  localparam int unsigned LEN_W  = 16;
  localparam int unsigned BEAT_W = 10;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_GAP} state_e;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    if (l < LEN_W'(MIN_LEN)) return LEN_W'(MIN_LEN);
    if (l > LEN_W'(MAX_LEN)) return LEN_W'(MAX_LEN);
    return l;
  endfunction

  function automatic logic [BEAT_W-1:0] last_beat(input logic [LEN_W-1:0] l);
    return BEAT_W'((32'(l) + KEEP_W - 1) / KEEP_W - 1);
  endfunction

  // Header (seq, len, A5 5A marker) then (index + seq) ramp; bytes past len are zero.
  function automatic logic [DATA_W-1:0] gen_data(input logic [BEAT_W-1:0] b,
                                                 input logic [31:0] s,
                                                 input logic [LEN_W-1:0] l);
    logic [DATA_W-1:0] d;
    logic [LEN_W-1:0]  i;
    logic [7:0]        v;
    d = '0;
    for (int j = 0; j < KEEP_W; j++) begin
      i = LEN_W'(32'(b) * KEEP_W + 32'(j));
      if (i >= l) v = 8'h00;
      else begin
        case (i)
          16'd0:   v = s[7:0];
          16'd1:   v = s[15:8];
          16'd2:   v = s[23:16];
          16'd3:   v = s[31:24];
          16'd4:   v = l[7:0];
          16'd5:   v = l[15:8];
          16'd6:   v = 8'hA5;
          16'd7:   v = 8'h5A;
          default: v = i[7:0] + s[7:0];
        endcase
      end
      d[8*j +: 8] = v;
    end
    return d;
  endfunction

  function automatic logic [KEEP_W-1:0] gen_keep(input logic [BEAT_W-1:0] b,
                                                 input logic [BEAT_W-1:0] lb,
                                                 input logic [LEN_W-1:0] l);
    logic [KEEP_W:0] m;
    if (b != lb || l[OFF_W-1:0] == '0) return '1;
    m    = '0;
    m[0] = 1'b1;
    m    = m << l[OFF_W-1:0];
    m    = m - 1'b1;
    return m[KEEP_W-1:0];
  endfunction

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [BEAT_W-1:0]   last_q, last_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [31:0]         count_q, count_d;
  logic [7:0]          gap_q, gap_d;
  logic [7:0]          gap_cnt_q, gap_cnt_d;
  logic [31:0]         seq_q, seq_d;
  logic                stop_pend_q, stop_pend_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [31:0]         pkt_cnt_q, pkt_cnt_d;
  logic [47:0]         byte_cnt_q, byte_cnt_d;
  logic                tvalid_q, tvalid_d;
  logic                tlast_q, tlast_d;
  logic [DATA_W-1:0]   tdata_q, tdata_d;
  logic [KEEP_W-1:0]   tkeep_q, tkeep_d;

  logic [LEN_W-1:0]    cfg_len_c;
  logic [BEAT_W-1:0]   cfg_last_c;
  logic [31:0]         pkt_cnt_inc_c;
  logic                ld_c;
  logic [BEAT_W-1:0]   ld_beat_c, ld_last_c;
  logic [31:0]         ld_seq_c;
  logic [LEN_W-1:0]    ld_len_c;

  assign cfg_len_c     = clamp_len(cfg_pkt_len);
  assign cfg_last_c    = last_beat(cfg_len_c);
  assign pkt_cnt_inc_c = pkt_cnt_q + 32'd1;

  // Next-state: ld_c requests a fresh beat to be built into the output register.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    last_d      = last_q;
    beat_d      = beat_q;
    count_d     = count_q;
    gap_d       = gap_q;
    gap_cnt_d   = gap_cnt_q;
    seq_d       = seq_q;
    stop_pend_d = stop_pend_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pkt_cnt_d   = pkt_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    tdata_d     = tdata_q;
    tkeep_d     = tkeep_q;
    ld_c        = 1'b0;
    ld_beat_c   = beat_q;
    ld_last_c   = last_q;
    ld_seq_c    = seq_q;
    ld_len_c    = len_q;

    case (state_q)
      S_IDLE: begin
        if (cfg_start && !cfg_stop) begin
          len_d       = cfg_len_c;
          last_d      = cfg_last_c;
          count_d     = cfg_pkt_count;
          gap_d       = cfg_gap;
          pkt_cnt_d   = '0;
          byte_cnt_d  = '0;
          seq_d       = '0;
          stop_pend_d = 1'b0;
          busy_d      = 1'b1;
          state_d     = S_DATA;
          ld_c        = 1'b1;
          ld_beat_c   = '0;
          ld_last_c   = cfg_last_c;
          ld_seq_c    = '0;
          ld_len_c    = cfg_len_c;
        end
      end
      S_DATA: begin
        if (cfg_stop) stop_pend_d = 1'b1;
        if (tvalid_q && m_axis_tready) begin
          if (!tlast_q) begin
            ld_c      = 1'b1;
            ld_beat_c = beat_q + 1'b1;
          end else begin
            pkt_cnt_d  = pkt_cnt_inc_c;
            byte_cnt_d = byte_cnt_q + 48'(len_q);
            seq_d      = seq_q + 32'd1;
            tvalid_d   = 1'b0;
            tlast_d    = 1'b0;
            tdata_d    = '0;
            tkeep_d    = '0;
            if ((count_q != '0 && pkt_cnt_inc_c == count_q) || stop_pend_q || cfg_stop) begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else if (gap_q != '0) begin
              state_d   = S_GAP;
              gap_cnt_d = gap_q;
            end else begin
              ld_c      = 1'b1;
              ld_beat_c = '0;
              ld_seq_c  = seq_q + 32'd1;
            end
          end
        end
      end
      S_GAP: begin
        if (cfg_stop) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (gap_cnt_q == 8'd1) begin
          state_d   = S_DATA;
          ld_c      = 1'b1;
          ld_beat_c = '0;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (ld_c) begin
      beat_d   = ld_beat_c;
      tvalid_d = 1'b1;
      tlast_d  = (ld_beat_c == ld_last_c);
      tdata_d  = gen_data(ld_beat_c, ld_seq_c, ld_len_c);
      tkeep_d  = gen_keep(ld_beat_c, ld_last_c, ld_len_c);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      last_q      <= '0;
      beat_q      <= '0;
      count_q     <= '0;
      gap_q       <= '0;
      gap_cnt_q   <= '0;
      seq_q       <= '0;
      stop_pend_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pkt_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tdata_q     <= '0;
      tkeep_q     <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      last_q      <= last_d;
      beat_q      <= beat_d;
      count_q     <= count_d;
      gap_q       <= gap_d;
      gap_cnt_q   <= gap_cnt_d;
      seq_q       <= seq_d;
      stop_pend_q <= stop_pend_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pkt_cnt_q   <= pkt_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      tdata_q     <= tdata_d;
      tkeep_q     <= tkeep_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign tx_pkt_cnt    = pkt_cnt_q;
  assign tx_byte_cnt   = byte_cnt_q;

endmodule

// File: tb/tb_udp_40g_traffic_gen.sv
// Directed bench for udp_40g_traffic_gen: reference byte-map model feeds a beat
// scoreboard; a stream monitor checks beats, AXI hold rules and inter-packet gaps.
module tb_udp_40g_traffic_gen;

  logic         sys_clk;
  logic         sys_reset_n;
  logic         cfg_start;
  logic         cfg_stop;
  logic [15:0]  cfg_pkt_len;
  logic [31:0]  cfg_pkt_count;
  logic [7:0]   cfg_gap;
  logic [127:0] m_axis_tdata;
  logic [15:0]  m_axis_tkeep;
  logic         m_axis_tvalid;
  logic         m_axis_tlast;
  logic         m_axis_tready;
  logic         busy;
  logic         done;
  logic [31:0]  tx_pkt_cnt;
  logic [47:0]  tx_byte_cnt;

  udp_40g_traffic_gen dut (
    .sys_clk       (sys_clk),
    .sys_reset_n   (sys_reset_n),
    .cfg_start     (cfg_start),
    .cfg_stop      (cfg_stop),
    .cfg_pkt_len   (cfg_pkt_len),
    .cfg_pkt_count (cfg_pkt_count),
    .cfg_gap       (cfg_gap),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .busy          (busy),
    .done          (done),
    .tx_pkt_cnt    (tx_pkt_cnt),
    .tx_byte_cnt   (tx_byte_cnt)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  typedef struct {
    logic [127:0] d;
    logic [15:0]  k;
    logic         l;
  } beat_t;

  beat_t sb[$];
  int vectors = 0;
  int errors  = 0;

  // Monitor state (written only by the forked monitor process).
  int           cyc = 0;
  int           hs_count = 0;
  int           last_tlast_cyc = 0;
  int           gap_m = 0;
  bit           measuring = 0;
  bit           prev_stall = 0;
  logic [127:0] pdata;
  logic [15:0]  pkeep;
  logic         plast;
  int           exp_gap = 0;
  beat_t        e;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mbyte(input int i, input logic [31:0] seq, input int len);
    logic [15:0] l16;
    l16 = 16'(len);
    if (i >= len) return 8'h00;
    case (i)
      0: return seq[7:0];
      1: return seq[15:8];
      2: return seq[23:16];
      3: return seq[31:24];
      4: return l16[7:0];
      5: return l16[15:8];
      6: return 8'hA5;
      7: return 8'h5A;
      default: return 8'((i + int'(seq[7:0])) % 256);
    endcase
  endfunction

  task automatic push_pkt(input logic [31:0] seq, input int raw_len);
    int len;
    int nb;
    beat_t bt;
    len = (raw_len < 16) ? 16 : (raw_len > 8192) ? 8192 : raw_len;
    nb  = (len + 15) / 16;
    for (int b = 0; b < nb; b++) begin
      for (int j = 0; j < 16; j++) begin
        bt.d[8*j +: 8] = mbyte(b*16 + j, seq, len);
        bt.k[j]        = (b*16 + j < len);
      end
      bt.l = (b == nb - 1);
      sb.push_back(bt);
    end
  endtask

  task automatic start_run(input int len, input int count, input int gap);
    @(posedge sys_clk); #1;
    cfg_pkt_len   = 16'(len);
    cfg_pkt_count = 32'(count);
    cfg_gap       = 8'(gap);
    cfg_start     = 1'b1;
    @(posedge sys_clk); #1;
    cfg_start     = 1'b0;
    cfg_pkt_len   = 16'hFFFF;
    cfg_pkt_count = 32'h1234;
    cfg_gap       = 8'hEE;
    chk("first_beat_valid", 128'(m_axis_tvalid), 128'(1));
    chk("busy_after_start", 128'(busy), 128'(1));
  endtask

  task automatic wait_done(input int maxc, input bit rnd);
    int n;
    n = 0;
    while (done !== 1'b1 && n < maxc) begin
      @(posedge sys_clk); #1;
      if (rnd) m_axis_tready = 1'($urandom_range(0, 1));
      n++;
    end
    chk("done_seen", 128'(done), 128'(1));
    chk("done_timing", 128'(cyc), 128'(last_tlast_cyc));
    chk("busy_drop", 128'(busy), 128'(0));
    chk("sb_drained", 128'(sb.size()), 128'(0));
    m_axis_tready = 1'b1;
    @(posedge sys_clk); #1;
    chk("done_one_cycle", 128'(done), 128'(0));
  endtask

  task automatic wait_hs(input int target, input int maxc);
    int n;
    n = 0;
    while (hs_count < target && n < maxc) begin
      @(posedge sys_clk); #1;
      n++;
    end
    chk("handshake_reach", 128'(hs_count), 128'(target));
  endtask

  initial begin
    int base;
    sys_reset_n   = 1'b0;
    cfg_start     = 1'b0;
    cfg_stop      = 1'b0;
    cfg_pkt_len   = '0;
    cfg_pkt_count = '0;
    cfg_gap       = '0;
    m_axis_tready = 1'b0;

    fork
      forever begin
        @(negedge sys_clk);
        cyc++;
        if (!sys_reset_n) begin
          prev_stall = 0;
          measuring  = 0;
        end else begin
          if (done) measuring = 0;
          if (prev_stall) begin
            chk("hold_valid", 128'(m_axis_tvalid), 128'(1));
            chk("hold_data", m_axis_tdata, pdata);
            chk("hold_keep_last", 128'({m_axis_tkeep, m_axis_tlast}), 128'({pkeep, plast}));
          end
          if (m_axis_tvalid) begin
            if (measuring) begin
              chk("gap_cycles", 128'(gap_m), 128'(exp_gap));
              measuring = 0;
            end
          end else if (measuring) begin
            gap_m++;
          end
          if (m_axis_tvalid && m_axis_tready) begin
            hs_count++;
            vectors++;
            assert (sb.size() != 0) else begin
              errors++;
              $error("FAIL unexpected_beat: observed data %0h with no expected beat", m_axis_tdata);
            end
            if (sb.size() != 0) begin
              e = sb.pop_front();
              chk("beat_data", m_axis_tdata, e.d);
              chk("beat_keep", 128'(m_axis_tkeep), 128'(e.k));
              chk("beat_last", 128'(m_axis_tlast), 128'(e.l));
            end
            if (m_axis_tlast) begin
              last_tlast_cyc = cyc;
              measuring      = 1;
              gap_m          = 0;
            end
          end
          prev_stall = m_axis_tvalid && !m_axis_tready;
          pdata      = m_axis_tdata;
          pkeep      = m_axis_tkeep;
          plast      = m_axis_tlast;
        end
      end
    join_none

    #12;
    chk("rst_tvalid", 128'(m_axis_tvalid), 128'(0));
    chk("rst_busy_done", 128'({busy, done, m_axis_tlast}), 128'(0));
    chk("rst_counters", 128'({tx_pkt_cnt, tx_byte_cnt}), 128'(0));
    chk("rst_data_keep", m_axis_tdata | 128'(m_axis_tkeep), 128'(0));
    @(posedge sys_clk); #1;
    sys_reset_n   = 1'b1;
    m_axis_tready = 1'b1;

    // Basic back-to-back run
    exp_gap = 0;
    push_pkt(0, 64);
    push_pkt(1, 64);
    start_run(64, 2, 0);
    wait_done(100, 0);
    chk("basic_pkt_cnt", 128'(tx_pkt_cnt), 128'(2));
    chk("basic_byte_cnt", 128'(tx_byte_cnt), 128'(128));

    // Partial last beat
    push_pkt(0, 70);
    start_run(70, 1, 0);
    wait_done(100, 0);
    chk("partial_pkt_cnt", 128'(tx_pkt_cnt), 128'(1));
    chk("partial_byte_cnt", 128'(tx_byte_cnt), 128'(70));

    // Random backpressure
    for (int p = 0; p < 10; p++) push_pkt(32'(p), 1500);
    start_run(1500, 10, 0);
    wait_done(8000, 1);
    chk("bp_pkt_cnt", 128'(tx_pkt_cnt), 128'(10));
    chk("bp_byte_cnt", 128'(tx_byte_cnt), 128'(15000));

    // Length clamp with idle gap
    exp_gap = 3;
    for (int p = 0; p < 3; p++) push_pkt(32'(p), 5);
    start_run(5, 3, 3);
    wait_done(100, 0);
    chk("clamp_pkt_cnt", 128'(tx_pkt_cnt), 128'(3));
    chk("clamp_byte_cnt", 128'(tx_byte_cnt), 128'(48));

    // Continuous run stopped on beat 7 of packet 4
    exp_gap = 0;
    for (int p = 0; p < 4; p++) push_pkt(32'(p), 256);
    base = hs_count;
    start_run(256, 0, 0);
    wait_hs(base + 55, 200);
    cfg_stop = 1'b1;
    @(posedge sys_clk); #1;
    cfg_stop = 1'b0;
    wait_done(100, 0);
    chk("stop_pkt_cnt", 128'(tx_pkt_cnt), 128'(4));
    chk("stop_byte_cnt", 128'(tx_byte_cnt), 128'(1024));

    // Start and stop together: stop wins
    cfg_pkt_len = 16'd64;
    cfg_start   = 1'b1;
    cfg_stop    = 1'b1;
    @(posedge sys_clk); #1;
    cfg_start = 1'b0;
    cfg_stop  = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("startstop_idle", 128'({busy, m_axis_tvalid}), 128'(0));
      @(posedge sys_clk); #1;
    end
    chk("startstop_cnt_hold", 128'(tx_pkt_cnt), 128'(4));

    // Reset during beat 3 of packet 3
    for (int p = 0; p < 3; p++) push_pkt(32'(p), 64);
    base = hs_count;
    start_run(64, 0, 0);
    wait_hs(base + 11, 100);
    chk("pre_reset_pkt_cnt", 128'(tx_pkt_cnt), 128'(2));
    sys_reset_n = 1'b0;
    #1;
    chk("mid_rst_tvalid_busy", 128'({m_axis_tvalid, busy}), 128'(0));
    chk("mid_rst_counters", 128'({tx_pkt_cnt, tx_byte_cnt}), 128'(0));
    sb.delete();
    repeat (2) @(posedge sys_clk);
    #1;
    sys_reset_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge sys_clk); #1;
      chk("post_rst_quiet", 128'({m_axis_tvalid, busy}), 128'(0));
    end
    push_pkt(0, 32);
    start_run(32, 1, 0);
    wait_done(100, 0);
    chk("post_rst_pkt_cnt", 128'(tx_pkt_cnt), 128'(1));
    chk("post_rst_byte_cnt", 128'(tx_byte_cnt), 128'(32));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
